// File: rtl/exe_stage_module_pkg.sv
// exe_stage_module_pkg: shared widths, ALU opcodes, shift types and status bit indices for the execute stage
package exe_stage_module_pkg;
  localparam int ADDRESS_LEN_D = 32;
  localparam int REGISTER_LEN_D = 32;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;
endpackage

// File: rtl/exe_stage_module_if.sv
// exe_stage_module_if: ID-register-to-EXE inputs and EXE outputs; master drives decoded fields, slave is the stage
interface exe_stage_module_if #(parameter int ADDRESS_LEN = 32, parameter int REGISTER_LEN = 32);
  logic freeze;
  logic [ADDRESS_LEN-1:0] PC_in;
  logic mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in;
  logic [3:0] execute_command_in;
  logic [REGISTER_LEN-1:0] reg_file_in1, reg_file_in2;
  logic [3:0] dest_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic branch_taken_out;
  logic [ADDRESS_LEN-1:0] branch_address_out;
  logic [3:0] status_out;
  logic wb_enable_out, mem_read_en_out, mem_write_en_out;
  logic [REGISTER_LEN-1:0] alu_result_out, store_data_out;
  logic [3:0] dest_reg_out;
  modport master (
    output freeze, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in,
           status_write_enable_in, execute_command_in, reg_file_in1, reg_file_in2, dest_reg_in,
           signed_immediate_in, shift_operand_in,
    input  branch_taken_out, branch_address_out, status_out, wb_enable_out, mem_read_en_out,
           mem_write_en_out, alu_result_out, store_data_out, dest_reg_out
  );
  modport slave (
    input  freeze, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in,
           status_write_enable_in, execute_command_in, reg_file_in1, reg_file_in2, dest_reg_in,
           signed_immediate_in, shift_operand_in,
    output branch_taken_out, branch_address_out, status_out, wb_enable_out, mem_read_en_out,
           mem_write_en_out, alu_result_out, store_data_out, dest_reg_out
  );
endinterface

// File: rtl/exe_stage_module_alu.sv
// alu: combinational ALU producing result and NZCV (ports: i_cmd, i_rn, i_val2, i_status -> o_result, o_nzcv)
module alu import exe_stage_module_pkg::*; #(parameter int W = REGISTER_LEN_D) (
  input  logic [3:0]   i_cmd,
  input  logic [W-1:0] i_rn,
  input  logic [W-1:0] i_val2,
  input  logic [3:0]   i_status,
  output logic [W-1:0] o_result,
  output logic [3:0]   o_nzcv
);
  logic w_add, w_sub, w_cin, w_c, w_v;
  logic [W-1:0] w_b;
  logic [W:0] w_sum;
  always_comb begin
    w_add = (i_cmd == EXE_ADD) || (i_cmd == EXE_ADC);
    w_sub = (i_cmd == EXE_SUB) || (i_cmd == EXE_SBC);
    // subtraction as Rn + ~Val2 + cin, so the carry-out is the not-borrow flag
    w_b = w_sub ? ~i_val2 : i_val2;
    w_cin = (i_cmd == EXE_SUB) ? 1'b1 :
            ((i_cmd == EXE_ADC) || (i_cmd == EXE_SBC)) ? i_status[ST_C] : 1'b0;
    w_sum = {1'b0, i_rn} + {1'b0, w_b} + {{W{1'b0}}, w_cin};
    o_result = (w_add || w_sub) ? w_sum[W-1:0] :
               (i_cmd == EXE_MOV) ? i_val2 :
               (i_cmd == EXE_MVN) ? ~i_val2 :
               (i_cmd == EXE_AND) ? i_rn & i_val2 :
               (i_cmd == EXE_ORR) ? i_rn | i_val2 :
               (i_cmd == EXE_EOR) ? i_rn ^ i_val2 : '0;
    w_c = (w_add || w_sub) ? w_sum[W] : i_status[ST_C];
    w_v = w_add ? (i_rn[W-1] == i_val2[W-1]) && (o_result[W-1] != i_rn[W-1]) :
          w_sub ? (i_rn[W-1] != i_val2[W-1]) && (o_result[W-1] != i_rn[W-1]) : i_status[ST_V];
    o_nzcv = {o_result[W-1], o_result == '0, w_c, w_v};
  end
endmodule

// File: rtl/exe_stage_module_val2.sv
// val2_generator: second ALU operand from rotated immediate, memory offset or shifted Rm (ports: i_imm, i_mem, i_rm, i_so -> o_val2)
module val2_generator import exe_stage_module_pkg::*; #(parameter int W = REGISTER_LEN_D) (
  input  logic         i_imm,
  input  logic         i_mem,
  input  logic [W-1:0] i_rm,
  input  logic [11:0]  i_so,
  output logic [W-1:0] o_val2
);
  logic [W-1:0] w_imm8, w_rot_imm, w_shifted;
  logic [4:0] w_rot, w_amt;
  shift_t w_type;
  always_comb begin
    w_imm8 = {{(W-8){1'b0}}, i_so[7:0]};
    w_rot = {i_so[11:8], 1'b0};
    // a shift by W yields zero, so rotate by 0 degenerates cleanly
    w_rot_imm = (w_imm8 >> w_rot) | (w_imm8 << (W - int'(w_rot)));
    w_amt = i_so[11:7];
    w_type = shift_t'(i_so[6:5]);
    w_shifted = (w_type == SH_LSL) ? i_rm << w_amt :
                (w_type == SH_LSR) ? i_rm >> w_amt :
                (w_type == SH_ASR) ? W'($signed(i_rm) >>> w_amt) :
                (i_rm >> w_amt) | (i_rm << (W - int'(w_amt)));
    o_val2 = i_imm ? w_rot_imm : i_mem ? {{(W-12){1'b0}}, i_so} : w_shifted;
  end
endmodule

// File: rtl/exe_stage_module.sv
// exe_stage_module: execute stage with EXE/MEM register, NZCV status register and branch target (ports: clk, rst, bus slave)
module exe_stage_module import exe_stage_module_pkg::*; #(
  parameter int ADDRESS_LEN = ADDRESS_LEN_D,
  parameter int REGISTER_LEN = REGISTER_LEN_D
) (
  input logic clk,
  input logic rst,
  exe_stage_module_if.slave bus
);
  logic [REGISTER_LEN-1:0] w_val2, w_result, r_result, r_store;
  logic [3:0] w_nzcv, r_status, r_dest;
  logic r_wb, r_mr, r_mw;
  val2_generator #(.W(REGISTER_LEN)) u_val2 (
    .i_imm(bus.immediate_in),
    .i_mem(bus.mem_read_en_in | bus.mem_write_en_in),
    .i_rm(bus.reg_file_in2),
    .i_so(bus.shift_operand_in),
    .o_val2(w_val2)
  );
  alu #(.W(REGISTER_LEN)) u_alu (
    .i_cmd(bus.execute_command_in),
    .i_rn(bus.reg_file_in1),
    .i_val2(w_val2),
    .i_status(r_status),
    .o_result(w_result),
    .o_nzcv(w_nzcv)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_store <= '0;
      r_dest <= '0;
      r_wb <= 1'b0;
      r_mr <= 1'b0;
      r_mw <= 1'b0;
      r_status <= '0;
    end else if (!bus.freeze) begin
      r_result <= w_result;
      r_store <= bus.reg_file_in2;
      r_dest <= bus.dest_reg_in;
      r_wb <= bus.wb_enable_in;
      r_mr <= bus.mem_read_en_in;
      r_mw <= bus.mem_write_en_in;
      if (bus.status_write_enable_in) r_status <= w_nzcv;
    end
  end
  assign bus.branch_taken_out = bus.branch_taken_in;
  assign bus.branch_address_out = bus.PC_in + {{(ADDRESS_LEN-26){bus.signed_immediate_in[23]}}, bus.signed_immediate_in, 2'b00};
  assign bus.status_out = r_status;
  assign bus.alu_result_out = r_result;
  assign bus.store_data_out = r_store;
  assign bus.dest_reg_out = r_dest;
  assign bus.wb_enable_out = r_wb;
  assign bus.mem_read_en_out = r_mr;
  assign bus.mem_write_en_out = r_mw;
endmodule

// File: tb/tb_exe_stage_module.sv
// tb_exe_stage_module: directed checks of the execute stage with hand-computed expectations
module tb_exe_stage_module;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exe_stage_module_if bus();
  exe_stage_module dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] cmd, input logic imm, mr, mw, wb, s,
                       input logic [31:0] rn, rm, input logic [11:0] so);
    bus.execute_command_in = cmd;
    bus.immediate_in = imm;
    bus.mem_read_en_in = mr;
    bus.mem_write_en_in = mw;
    bus.wb_enable_in = wb;
    bus.status_write_enable_in = s;
    bus.reg_file_in1 = rn;
    bus.reg_file_in2 = rm;
    bus.shift_operand_in = so;
  endtask
  initial begin
    bus.freeze = 1'b0;
    bus.PC_in = '0;
    bus.branch_taken_in = 1'b0;
    bus.dest_reg_in = 4'd0;
    bus.signed_immediate_in = '0;
    drive(4'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 12'd0);
    step();
    step();
    chk("rst_alu", bus.alu_result_out, 32'd0);
    chk("rst_store", bus.store_data_out, 32'd0);
    chk("rst_dest", {28'd0, bus.dest_reg_out}, 32'd0);
    chk("rst_ctl", {29'd0, bus.wb_enable_out, bus.mem_read_en_out, bus.mem_write_en_out}, 32'd0);
    chk("rst_status", {28'd0, bus.status_out}, 32'd0);
    rst = 1'b0;
    bus.dest_reg_in = 4'd3;
    drive(4'b0010, 1, 0, 0, 1, 1, 32'd1, 32'd0, 12'h2FF);
    step();
    chk("add_imm", bus.alu_result_out, 32'hF0000010);
    chk("add_imm_st", {28'd0, bus.status_out}, 32'h8);
    chk("add_imm_wb", {31'd0, bus.wb_enable_out}, 32'd1);
    chk("add_imm_dest", {28'd0, bus.dest_reg_out}, 32'd3);
    drive(4'b0100, 0, 0, 0, 1, 1, 32'd5, 32'd5, 12'h000);
    step();
    chk("sub_zero", bus.alu_result_out, 32'd0);
    chk("sub_st", {28'd0, bus.status_out}, 32'h6);
    drive(4'b0011, 0, 0, 0, 1, 1, 32'd1, 32'd1, 12'h000);
    step();
    chk("adc_carry", bus.alu_result_out, 32'd3);
    chk("adc_st", {28'd0, bus.status_out}, 32'h0);
    drive(4'b0010, 0, 0, 0, 1, 1, 32'h7FFFFFFF, 32'd1, 12'h000);
    step();
    chk("add_ovf", bus.alu_result_out, 32'h80000000);
    chk("add_ovf_st", {28'd0, bus.status_out}, 32'h9);
    drive(4'b0001, 0, 0, 0, 1, 0, 32'd0, 32'h80000000, 12'h240);
    step();
    chk("mov_asr", bus.alu_result_out, 32'hF8000000);
    chk("mov_asr_st", {28'd0, bus.status_out}, 32'h9);
    drive(4'b0001, 0, 0, 0, 1, 0, 32'd0, 32'h000000F1, 12'h260);
    step();
    chk("mov_ror", bus.alu_result_out, 32'h1000000F);
    drive(4'b0001, 0, 0, 0, 1, 0, 32'd0, 32'd1, 12'hF80);
    step();
    chk("mov_lsl", bus.alu_result_out, 32'h80000000);
    drive(4'b0110, 0, 0, 0, 1, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000);
    step();
    chk("and", bus.alu_result_out, 32'h0F000F00);
    drive(4'b0001, 1, 0, 0, 1, 1, 32'd0, 32'd0, 12'h000);
    step();
    chk("movs_zero", bus.alu_result_out, 32'd0);
    chk("movs_st", {28'd0, bus.status_out}, 32'h5);
    bus.PC_in = 32'h100;
    bus.signed_immediate_in = 24'hFFFFFE;
    bus.branch_taken_in = 1'b1;
    #1;
    chk("br_addr", bus.branch_address_out, 32'hF8);
    chk("br_taken", {31'd0, bus.branch_taken_out}, 32'd1);
    bus.freeze = 1'b1;
    bus.branch_taken_in = 1'b0;
    bus.dest_reg_in = 4'd7;
    drive(4'b0010, 0, 0, 1, 0, 1, 32'h1000, 32'hDEADBEEF, 12'h004);
    bus.PC_in = 32'h200;
    bus.signed_immediate_in = 24'h000001;
    #1;
    chk("frz_br_addr", bus.branch_address_out, 32'h204);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_alu", bus.alu_result_out, 32'd0);
      chk("frz_mw", {31'd0, bus.mem_write_en_out}, 32'd0);
      chk("frz_wb", {31'd0, bus.wb_enable_out}, 32'd1);
      chk("frz_st", {28'd0, bus.status_out}, 32'h5);
    end
    bus.freeze = 1'b0;
    step();
    chk("str_mw", {31'd0, bus.mem_write_en_out}, 32'd1);
    chk("str_addr", bus.alu_result_out, 32'h1004);
    chk("str_data", bus.store_data_out, 32'hDEADBEEF);
    chk("str_wb", {31'd0, bus.wb_enable_out}, 32'd0);
    chk("str_dest", {28'd0, bus.dest_reg_out}, 32'd7);
    chk("str_st", {28'd0, bus.status_out}, 32'h0);
    drive(4'b0010, 0, 1, 0, 1, 0, 32'h100, 32'd0, 12'hFFF);
    step();
    chk("ldr_addr", bus.alu_result_out, 32'h10FF);
    chk("ldr_mr", {31'd0, bus.mem_read_en_out}, 32'd1);
    drive(4'b0100, 0, 0, 0, 1, 1, 32'd0, 32'd1, 12'h000);
    step();
    chk("sub_neg", bus.alu_result_out, 32'hFFFFFFFF);
    chk("sub_neg_st", {28'd0, bus.status_out}, 32'h8);
    drive(4'b0101, 0, 0, 0, 1, 0, 32'd10, 32'd3, 12'h000);
    step();
    chk("sbc_borrow", bus.alu_result_out, 32'd6);
    rst = 1'b1;
    drive(4'b0010, 0, 0, 1, 1, 1, 32'h80000000, 32'h80000000, 12'h000);
    step();
    chk("mid_rst_alu", bus.alu_result_out, 32'd0);
    chk("mid_rst_ctl", {29'd0, bus.wb_enable_out, bus.mem_read_en_out, bus.mem_write_en_out}, 32'd0);
    chk("mid_rst_st", {28'd0, bus.status_out}, 32'h0);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
